// File: rtl/outport_serial_tx_pkg.sv
// Shared definitions for the OutPort serial transmitter and its matching receiver:
// FSM state encodings, serial line idle level and a counter-width helper.
package outport_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/outport_serial_tx_fifo.sv
// Synchronous FIFO holding queued OutPort words; the occupancy count is the
// single source of full/empty so pointers may wrap freely.
module io_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still legal when a pop frees the head slot that same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/outport_serial_tx.sv
// OutPort serial transmitter: buffers CPU OutPort writes and shifts each word out
// LSB first as a start/data/stop frame on a single idle-high line.
module outport_serial_tx
    import outport_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          out_wr,
    input  logic [DATA_WIDTH-1:0]         out_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          tx_serial,
    output logic                          frame_done,
    output logic                          overflow
);

    localparam int CNT_W = cnt_width(BIT_CYCLES);
    localparam int IDX_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;
    logic                  done_q;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  stop_pre_end;
    logic                  pop;

    io_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (out_wr),
        .pop_i   (pop),
        .data_i  (out_data),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end      = (cnt_q == CNT_LAST);
    assign stop_pre_end = (BIT_CYCLES >= 2) && (int'(cnt_q) == BIT_CYCLES - 2);

    // The next word leaves the FIFO either from idle or at the last STOP cycle, so frames run back to back.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_serial  = tx_q;
    assign frame_done = done_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= LINE_IDLE;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            overflow_q <= overflow_q | (out_wr & fifo_full & ~pop);
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_head;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            tx_q    <= LINE_IDLE;
                            done_q  <= (BIT_CYCLES == 1);
                            state_q <= ST_STOP;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_head;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        done_q <= stop_pre_end;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
